// File: rtl/regfile_read_port_if.sv
// Request/response bundle between the operand requester, the read port and the consumer.
//   rd_req/rd_ready/ra/rb     : read request handshake and the two read addresses
//   out_valid/out_ready/qa/qb : result handshake and the two operand values
// master: requester/consumer side. slave: the read port.
interface regfile_read_port_if #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 32
);
   logic          rd_req;
   logic          rd_ready;
   logic [AW-1:0] ra;
   logic [AW-1:0] rb;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] qa;
   logic [DW-1:0] qb;

   modport master (
      output rd_req, ra, rb, out_ready,
      input  rd_ready, out_valid, qa, qb
   );

   modport slave (
      input  rd_req, ra, rb, out_ready,
      output rd_ready, out_valid, qa, qb
   );
endinterface

// File: rtl/regfile_read_port.sv
// Read side of the register file: snapshots {regs[ra], regs[rb]} on each accepted
// request into a 2-entry buffer and presents the head entry with valid/ready.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   regs_flat         : register contents, register i at [i*DW +: DW]
//   wr_ld/wr_addr/... : write-side strobe, used only for same-cycle bypass
//   rd_count          : completed output transfers (wraps at 16 bits)
//   bus (slave)       : rd_req/rd_ready/ra/rb request, out_valid/out_ready/qa/qb result
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write into a
// captured entry (write-before-read); otherwise the old register value is captured.
module regfile_read_port #(
   parameter int unsigned NREGS = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned DW    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREGS*DW-1:0]  regs_flat,
   input  logic                 wr_ld,
   input  logic [AW-1:0]        wr_addr,
   input  logic [DW-1:0]        wr_data,
   output logic [15:0]          rd_count,
   regfile_read_port_if.slave   bus
);

   localparam int unsigned CW = 16;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;
   entry_t         head;
   entry_t         tail;
   entry_t         cap_c;
   logic [DW-1:0]  regs [NREGS];
   logic           rd_ready_q;
   logic           out_valid_q;
   logic [CW-1:0]  count_q;
   logic           accept_c;
   logic           transfer_c;
   logic           load_head_c;
   logic           load_tail_c;
   logic           shift_c;

   // Unpack the flattened storage bus
   always_comb begin
      for (int unsigned i = 0; i < NREGS; i++) begin
         regs[i] = regs_flat[i*DW +: DW];
      end
   end

   // Entry captured on accept; addresses beyond the file read as zero
   always_comb begin
      cap_c = '0;
      if (32'(bus.ra) < NREGS) cap_c.a = regs[bus.ra];
      if (32'(bus.rb) < NREGS) cap_c.b = regs[bus.rb];
`ifdef REGFILE_BYPASS_EN
      if (wr_ld && (wr_addr == bus.ra)) cap_c.a = wr_data;
      if (wr_ld && (wr_addr == bus.rb)) cap_c.b = wr_data;
`endif
   end

`ifndef REGFILE_BYPASS_EN
   logic unused_wr;
   assign unused_wr = ^{wr_ld, wr_addr, wr_data};
`endif

   assign accept_c   = bus.rd_req && rd_ready_q;
   assign transfer_c = out_valid_q && bus.out_ready;

   // Buffer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;
   end

   // Next state and buffer load controls
   always_comb begin
      state_nx    = state;
      load_head_c = 1'b0;
      load_tail_c = 1'b0;
      shift_c     = 1'b0;
      case (state)
         EMPTY: begin
            if (accept_c) begin
               state_nx    = ONE;
               load_head_c = 1'b1;
            end
         end
         ONE: begin
            if (accept_c && transfer_c) begin
               load_head_c = 1'b1;
            end else if (accept_c) begin
               state_nx    = TWO;
               load_tail_c = 1'b1;
            end else if (transfer_c) begin
               state_nx    = EMPTY;
            end
         end
         TWO: begin
            if (transfer_c) begin
               state_nx = ONE;
               shift_c  = 1'b1;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   // Registered handshake flags follow the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         rd_ready_q  <= (state_nx != TWO);
         out_valid_q <= (state_nx != EMPTY);
      end
   end

   // Head drives qa/qb directly; tail only holds the second entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (load_head_c)  head <= cap_c;
         else if (shift_c) head <= tail;
         if (load_tail_c)  tail <= cap_c;
      end
   end

   // Completed transfer counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          count_q <= '0;
      else if (transfer_c) count_q <= count_q + CW'(1);
   end

   assign bus.rd_ready  = rd_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.qa        = head.a;
   assign bus.qb        = head.b;
   assign rd_count      = count_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: table of directed vectors, hand-written corner
// sequences (same-cycle write, snapshot, async reset, counter wrap) and a random
// phase checked against a queue-based model of the 2-entry buffer.
module tb_regfile_read_port;
   localparam int unsigned NREGS = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 32;

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] EXP_SAME = 32'hAABBAABB;
`else
   localparam logic [31:0] EXP_SAME = 32'hAAAA0000;
`endif

   logic                clk;
   logic                rst_n;
   logic [DW-1:0]       regs [NREGS];
   logic [NREGS*DW-1:0] regs_flat;
   logic                wr_ld;
   logic [AW-1:0]       wr_addr;
   logic [DW-1:0]       wr_data;
   logic [15:0]         rd_count;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] mq [$];
   logic [15:0] m_cnt;

   typedef struct {
      logic        req;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic        ordy;
      logic        exp_valid;
      logic        exp_ready;
      logic [15:0] exp_cnt;
      logic        chk_q;
      logic [31:0] exp_qa;
      logic [31:0] exp_qb;
   } vec_t;

   vec_t vecs [12];

   regfile_read_port_if #(.AW(AW), .DW(DW)) bus ();

   regfile_read_port #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .regs_flat (regs_flat),
      .wr_ld     (wr_ld),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_count  (rd_count),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      for (int i = 0; i < NREGS; i++) regs_flat[i*DW +: DW] = regs[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic req, input logic [3:0] ra, input logic [3:0] rb, input logic ordy);
      bus.rd_req    = req;
      bus.ra        = ra;
      bus.rb        = rb;
      bus.out_ready = ordy;
   endtask

   // One clock; the bench plays the storage array, so a strobed write lands after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (wr_ld) regs[wr_addr] = wr_data;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr_ld = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mq.delete();
      m_cnt = '0;
   endtask

   task automatic check_state(input string tag, input logic v, input logic r, input logic [15:0] c);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, "_ready"}, 32'(bus.rd_ready), 32'(r));
      chk({tag, "_count"}, 32'(rd_count), 32'(c));
   endtask

   // Model: FIFO of at most two snapshots, pop on transfer then push on accept
   task automatic mstep();
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] h;
      bit acc;
      bit xfer;
      a = regs[bus.ra];
      b = regs[bus.rb];
`ifdef REGFILE_BYPASS_EN
      if (wr_ld && wr_addr == bus.ra) a = wr_data;
      if (wr_ld && wr_addr == bus.rb) b = wr_data;
`endif
      acc  = bus.rd_req && (mq.size() < 2);
      xfer = (mq.size() > 0) && bus.out_ready;
      if (xfer) begin
         void'(mq.pop_front());
         m_cnt = m_cnt + 16'd1;
      end
      if (acc) mq.push_back({a, b});
      tick();
      check_state("rand", mq.size() != 0, mq.size() < 2, m_cnt);
      if (mq.size() != 0) begin
         h = mq[0];
         chk("rand_qa", bus.qa, h[63:32]);
         chk("rand_qb", bus.qb, h[31:0]);
      end
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) regs[i] = '0;
      regs[0]  = 32'h12345678;
      regs[1]  = 32'h11111111;
      regs[2]  = 32'h22222222;
      regs[3]  = 32'hFFFFFF00;
      regs[4]  = 32'h44444444;
      regs[5]  = 32'hAAAA0000;
      regs[7]  = 32'h0000FFFF;
      regs[15] = 32'h0F0F0F0F;

      //            req  ra    rb    ordy  valid ready cnt    chkq  qa            qb
      vecs[0]  = '{1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1, 32'hFFFFFF00, 32'h0000FFFF};
      vecs[1]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 32'h0,        32'h0};
      vecs[2]  = '{1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 32'h11111111, 32'h11111111};
      vecs[3]  = '{1'b1, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 32'h11111111, 32'h11111111};
      vecs[4]  = '{1'b1, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 32'h11111111, 32'h11111111};
      vecs[5]  = '{1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 32'h22222222, 32'h22222222};
      vecs[6]  = '{1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 16'd3, 1'b1, 32'hFFFFFF00, 32'hFFFFFF00};
      vecs[7]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0, 32'h0,        32'h0};
      vecs[8]  = '{1'b1, 4'd5, 4'd15,1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 32'hAAAA0000, 32'h0F0F0F0F};
      vecs[9]  = '{1'b1, 4'd7, 4'd3, 1'b1, 1'b1, 1'b1, 16'd5, 1'b1, 32'h0000FFFF, 32'hFFFFFF00};
      vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 16'd6, 1'b0, 32'h0,        32'h0};
      vecs[11] = '{1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 16'd6, 1'b1, 32'h12345678, 32'h12345678};

      do_reset();
      check_state("reset", 1'b0, 1'b1, 16'd0);
      chk("reset_qa", bus.qa, 32'h0);
      chk("reset_qb", bus.qb, 32'h0);

      // Directed vectors: basic read, back-pressure ordering, identical addresses
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].req, vecs[i].ra, vecs[i].rb, vecs[i].ordy);
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_cnt);
         if (vecs[i].chk_q) begin
            chk($sformatf("vec%0d_qa", i), bus.qa, vecs[i].exp_qa);
            chk($sformatf("vec%0d_qb", i), bus.qb, vecs[i].exp_qb);
         end
      end
      drive(1'b0, 4'd0, 4'd0, 1'b1);
      tick();
      check_state("drain", 1'b0, 1'b1, 16'd7);

      // Same-cycle write to the requested register
      drive(1'b1, 4'd5, 4'd2, 1'b0);
      wr_ld = 1'b1;
      wr_addr = 4'd5;
      wr_data = 32'hAABBAABB;
      tick();
      wr_ld = 1'b0;
      chk("samecyc_qa", bus.qa, EXP_SAME);
      chk("samecyc_qb", bus.qb, 32'h22222222);

      // Snapshot: captured entry survives a later storage change
      drive(1'b1, 4'd4, 4'd4, 1'b0);
      tick();
      chk("snap_ready", 32'(bus.rd_ready), 32'd0);
      regs[4] = 32'hDEADBEEF;
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      chk("snap_hold_qa", bus.qa, EXP_SAME);
      bus.out_ready = 1'b1;
      tick();
      chk("snap_qa", bus.qa, 32'h44444444);
      chk("snap_qb", bus.qb, 32'h44444444);
      check_state("snap", 1'b1, 1'b1, 16'd8);
      tick();
      check_state("snap_end", 1'b0, 1'b1, 16'd9);

      // Asynchronous reset with two entries buffered
      drive(1'b1, 4'd1, 4'd2, 1'b0);
      tick();
      drive(1'b1, 4'd2, 4'd1, 1'b0);
      tick();
      chk("pre_rst_ready", 32'(bus.rd_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_state("async_rst", 1'b0, 1'b1, 16'd0);
      chk("async_rst_qa", bus.qa, 32'h0);
      chk("async_rst_qb", bus.qb, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if (!(bus.rd_req && mq.size() >= 2)) begin
            bus.ra     = 4'($urandom_range(0, 15));
            bus.rb     = 4'($urandom_range(0, 15));
            bus.rd_req = ($urandom_range(0, 9) < 7);
         end
         bus.out_ready = ($urandom_range(0, 9) < 6);
         wr_ld   = ($urandom_range(0, 3) == 0);
         wr_addr = ($urandom_range(0, 1) == 0) ? bus.ra : 4'($urandom_range(0, 15));
         wr_data = $urandom();
         mstep();
      end
      wr_ld = 1'b0;

      // Counter wrap: 65535 transfers, then one more
      do_reset();
      drive(1'b1, 4'd0, 4'd0, 1'b1);
      repeat (65536) @(posedge clk);
      #1;
      chk("wrap_pre", 32'(rd_count), 32'h0000FFFF);
      drive(1'b0, 4'd0, 4'd0, 1'b1);
      tick();
      chk("wrap_cnt", 32'(rd_count), 32'h00000000);
      chk("wrap_valid", 32'(bus.out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
